// File: rtl/seq_mul_if.sv
// seq_mul_if: operand/product handshake bundle between operand source and seq_mul_ctrl
//   start        request, honoured only while ready=1
//   a, b         unsigned WIDTH-bit multiplicand and multiplier
//   ready        sequencer idle and able to accept start
//   busy         multiplication in progress
//   done         one-cycle pulse when product has just been updated
//   product      unsigned 2*WIDTH-bit result, held until the next result
interface seq_mul_if #(
    parameter int WIDTH = 4
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );
    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: shift-and-add sequencer producing an unsigned WIDTH x WIDTH product
//   clk          rising-edge clock
//   rst          synchronous active-high reset, aborts any operation in flight
//   bus          seq_mul_if slave: start/a/b in, ready/busy/done/product out
module seq_mul_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    seq_mul_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   a_q;
    logic               c_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH-1:0]   sum;
    logic               cy;
    logic [WIDTH-1:0]   a_sel;
    logic               c_sel;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   q_d;
    logic [CW-1:0]      cnt_d;
    // C is cleared every iteration, so as carry-in it only ever adds zero
    assign {cy, sum} = {1'b0, a_q} + {1'b0, m_q} + {{WIDTH{1'b0}}, c_q};
    always_comb begin
        a_sel = q_q[0] ? sum : a_q;
        c_sel = q_q[0] & cy;
        a_d   = {c_sel, a_sel[WIDTH-1:1]};
        q_d   = {a_sel[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    m_q     <= bus.a;
                    q_q     <= bus.b;
                    a_q     <= '0;
                    c_q     <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    c_q   <= 1'b0;
                    cnt_q <= cnt_d;
                    // product takes the freshly shifted {A,Q}, not the stale registers
                    if (cnt_d == CW'(WIDTH)) begin
                        product_q <= {a_d, q_d};
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.ready   = state_q == IDLE;
    assign bus.busy    = state_q == RUN;
    assign bus.done    = state_q == DONE;
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// tb_seq_mul_ctrl: directed self-checking bench for seq_mul_ctrl
module tb_seq_mul_ctrl;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] last_p = 8'h00;
    seq_mul_if bus ();
    seq_mul_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] exp);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_e0", 8'(bus.busy), 8'h01);
        chk("product_not_cleared", bus.product, last_p);
        repeat (3) begin
            tick();
            chk("busy_run", 8'(bus.busy), 8'h01);
            chk("ready_run", 8'(bus.ready), 8'h00);
            chk("done_run", 8'(bus.done), 8'h00);
            chk("product_old_run", bus.product, last_p);
        end
        tick();
        chk("done_e4", 8'(bus.done), 8'h01);
        chk("busy_e4", 8'(bus.busy), 8'h00);
        chk("product", bus.product, exp);
        tick();
        chk("done_one_cycle", 8'(bus.done), 8'h00);
        chk("ready_after", 8'(bus.ready), 8'h01);
        chk("product_hold", bus.product, exp);
        last_p = exp;
    endtask
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = 4'h0;
        bus.b = 4'h0;
        tick();
        tick();
        chk("rst_ready", 8'(bus.ready), 8'h01);
        chk("rst_busy", 8'(bus.busy), 8'h00);
        chk("rst_done", 8'(bus.done), 8'h00);
        chk("rst_product", bus.product, 8'h00);
        rst = 1'b0;
        tick();
        chk("idle_hold", 8'(bus.ready), 8'h01);
        op(4'hD, 4'hB, 8'h8F);
        op(4'hF, 4'hF, 8'hE1);
        op(4'h0, 4'h7, 8'h00);
        op(4'h1, 4'hF, 8'h0F);
        // start held high: back-to-back results six cycles apart
        bus.a = 4'h3;
        bus.b = 4'h5;
        bus.start = 1'b1;
        tick();
        chk("hold_busy_e0", 8'(bus.busy), 8'h01);
        bus.a = 4'h9;
        bus.b = 4'h9;
        repeat (3) tick();
        chk("hold_not_done_e3", 8'(bus.done), 8'h00);
        bus.a = 4'h3;
        bus.b = 4'h5;
        tick();
        chk("hold_done_e4", 8'(bus.done), 8'h01);
        chk("hold_product1", bus.product, 8'h0F);
        tick();
        chk("hold_ready_e5", 8'(bus.ready), 8'h01);
        chk("hold_done_e5", 8'(bus.done), 8'h00);
        tick();
        chk("hold_busy_e6", 8'(bus.busy), 8'h01);
        bus.a = 4'h2;
        bus.b = 4'h2;
        repeat (3) tick();
        chk("hold_not_done_e9", 8'(bus.done), 8'h00);
        tick();
        chk("hold_done_e10", 8'(bus.done), 8'h01);
        chk("hold_product2", bus.product, 8'h0F);
        bus.start = 1'b0;
        tick();
        chk("hold_ready_end", 8'(bus.ready), 8'h01);
        last_p = 8'h0F;
        // start pulsed mid-run with new operands is ignored
        bus.a = 4'h2;
        bus.b = 4'h6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.a = 4'h7;
        bus.b = 4'h7;
        bus.start = 1'b1;
        tick();
        chk("ign_ready", 8'(bus.ready), 8'h00);
        chk("ign_busy", 8'(bus.busy), 8'h01);
        bus.start = 1'b0;
        tick();
        chk("ign_ready2", 8'(bus.ready), 8'h00);
        tick();
        chk("ign_done", 8'(bus.done), 8'h01);
        chk("ign_product", bus.product, 8'h0C);
        tick();
        chk("ign_idle", 8'(bus.ready), 8'h01);
        last_p = 8'h0C;
        // reset on the second RUN cycle aborts the operation
        bus.a = 4'h5;
        bus.b = 4'h5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("abort_busy", 8'(bus.busy), 8'h01);
        rst = 1'b1;
        tick();
        chk("abort_ready", 8'(bus.ready), 8'h01);
        chk("abort_busy0", 8'(bus.busy), 8'h00);
        chk("abort_done", 8'(bus.done), 8'h00);
        chk("abort_product", bus.product, 8'h00);
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_no_done", 8'(bus.done), 8'h00);
        end
        last_p = 8'h00;
        op(4'h6, 4'h7, 8'h2A);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
